ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Consumer side of the program counter interface.
- Samples the PC's registered instruction address, issues one outstanding read to instruction memory over a valid/ready request channel, and buffers address/instruction pairs in a small FIFO for decode.
- Drives the PC's advance enable, so the PC only steps when a fetch has been accepted or a redirect is requested.
- Sits between the pc32 counter, the instruction memory port and the decode stage.

Parameters:
- DEPTH, 4: FIFO entries, power of two, ≥2.
- AW, `FULLW: address width.
- DW, `FULLW: instruction width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_addr  in  AW  registered PC address (iaddrout)
- pc_adv  out  1  PC advance enable (to PC mod_en)
- flush  in  1  redirect; asserted in the same cycle as the PC write enable
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  AW  read address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid, one pulse per accepted request
- imem_rsp_data  in  DW  read data
- inst_valid  out  1  FIFO head valid
- inst_data  out  DW  FIFO head instruction
- inst_addr  out  AW  FIFO head address
- inst_ready  in  1  decode pops head

Behaviour:
- The PC output lags its counter by one edge. After any PC step, pc_addr is valid only after one SETTLE cycle.
- FSM states:
  - SETTLE: wait one cycle, then go to REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc_addr. Valid only when credits>0; otherwise hold in REQ with valid low.
  - WAIT: wait for imem_rsp_valid.
  - DRAIN: discard one stale response.
- Credits: DEPTH − (FIFO count) − (outstanding request). This guarantees every response has a FIFO slot.
- REQ with imem_req_valid && imem_req_ready:
  - pc_adv=1 for that cycle.
  - Latch the address into a pending register.
  - Go to WAIT.
- The request stays stable while valid && !ready. The address is re-sampled each cycle; pc_addr cannot change while pc_adv=0.
- WAIT with imem_rsp_valid: push {pending addr, data}, then go to SETTLE.
  - The response may arrive earliest one cycle after acceptance.
- pc_adv = request accepted | flush. The combinational output makes the PC apply wd on flush.
- flush, any state, highest priority:
  - FIFO is cleared; inst_valid=0 next cycle.
  - Next state: DRAIN if a request is outstanding (WAIT, or REQ accepted in the same cycle), else SETTLE.
  - A response arriving in the same cycle as flush is discarded, and the unit goes to SETTLE.
- DRAIN: on imem_rsp_valid discard the data and go to SETTLE. A flush during DRAIN keeps the unit in DRAIN.
- FIFO rules:
  - Push and pop in the same cycle are both performed.
  - Pop only when inst_valid && inst_ready.
  - Pointers wrap modulo DEPTH.
  - Count ranges 0..DEPTH.
  - inst_valid = (count≠0). A push is visible at the head the next cycle; no bypass.
- Reset values:
  - state=SETTLE
  - FIFO empty, inst_valid=0, inst_data=0, inst_addr=0
  - imem_req_valid=0, pc_adv=0
  - No outstanding request; any response arriving during or after reset is ignored.
  - Reset mid-transaction discards everything.
- Reset has priority over flush.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- Defined:
  - Adds outputs stat_fetch (32b), count of accepted requests.
  - Adds stat_stall (32b), count of cycles in REQ with credits==0 or with valid && !ready.
  - Both counters clear on reset and saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- defines.v holds FULLW plus the FSM state encodings IF_SETTLE, IF_REQ, IF_WAIT, IF_DRAIN.
- Sub-module ifetch_fifo: parameterised sync FIFO (width AW+DW, DEPTH) with push, pop, clear, count, head outputs.
- The FSM, credit logic and stats stay in ifetch_unit.

Test Plan:
- Reset release, ready always 1, 1-cycle response latency, inst_ready=1, PC model starting at 0 → requests at 0x0, 0x4, 0x8; one pc_adv pulse each; instructions exit in order with matching inst_addr.
- inst_ready=0, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid stays 0. One pop → exactly one new request.
- imem_req_ready low for 3 cycles → imem_req_addr stable, pc_adv=0 throughout; single pc_adv on acceptance.
- flush with wd=0x100 while in WAIT → FIFO empties; the next response is dropped; the next request address is 0x100 with a SETTLE cycle before it.
- flush in the same cycle as imem_rsp_valid → that data is not pushed; the next fetch is from the flush target.
- With IFETCH_STATS_EN: 5 fetches plus 3 backpressure cycles → stat_fetch=5, stat_stall=3.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction fetch unit: datapath width, FSM states,
// and a saturating counter helper.
package ifetch_unit_pkg;

   localparam int FULLW = 32;

   typedef enum logic [1:0] {
      IF_SETTLE = 2'd0,
      IF_REQ    = 2'd1,
      IF_WAIT   = 2'd2,
      IF_DRAIN  = 2'd3
   } if_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Bus bundle for ifetch_unit: instruction-memory request/response channel
// and the decode-side instruction channel.
interface ifetch_unit_if import ifetch_unit_pkg::*; #(
   parameter int AW = FULLW,
   parameter int DW = FULLW
);
   logic          imem_req_valid;
   logic [AW-1:0] imem_req_addr;
   logic          imem_req_ready;
   logic          imem_rsp_valid;
   logic [DW-1:0] imem_rsp_data;
   logic          inst_valid;
   logic [DW-1:0] inst_data;
   logic [AW-1:0] inst_addr;
   logic          inst_ready;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst_data, inst_addr,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst_data, inst_addr,
      output inst_ready
   );
endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding {address, instruction} pairs; the head is read
// straight from storage, so a push becomes visible one cycle later.
module ifetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop_s  = pop && (count_r != {CW{1'b0}});
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem read, credit-limited against
// a small FIFO, and PC advance control. IFETCH_STATS_EN adds fetch/stall counters.
module ifetch_unit import ifetch_unit_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int AW    = FULLW,
   parameter int DW    = FULLW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc_addr,
   output logic          pc_adv,
   input  logic          flush,
   ifetch_unit_if.master ifc
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0]   stat_fetch,
   output logic [31:0]   stat_stall
`endif
);
   localparam int CW = $clog2(DEPTH + 1);

   if_state_e     state_r;
   if_state_e     state_nxt_s;
   logic [AW-1:0] pend_addr_r;
   logic [CW-1:0] count_s;
   logic [CW-1:0] credits_s;
   logic          outst_s;
   logic          req_valid_s;
   logic          accept_s;
   logic          push_s;
   logic          pop_s;

   // Credits reserve a FIFO slot for every response that can still arrive.
   always_comb begin
      outst_s     = (state_r == IF_WAIT) || (state_r == IF_DRAIN);
      credits_s   = CW'(DEPTH) - count_s - {{(CW-1){1'b0}}, outst_s};
      req_valid_s = !reset && (state_r == IF_REQ) && (credits_s != {CW{1'b0}});
      accept_s    = req_valid_s && ifc.imem_req_ready;
      push_s      = !reset && (state_r == IF_WAIT) && ifc.imem_rsp_valid && !flush;
      pop_s       = (count_s != {CW{1'b0}}) && ifc.inst_ready;
   end

   // Next-state: a flush wins over everything and drains any live request.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         if ((outst_s && !ifc.imem_rsp_valid) || accept_s) begin
            state_nxt_s = IF_DRAIN;
         end else begin
            state_nxt_s = IF_SETTLE;
         end
      end else begin
         case (state_r)
            IF_SETTLE: state_nxt_s = IF_REQ;
            IF_REQ:    state_nxt_s = accept_s ? IF_WAIT : IF_REQ;
            IF_WAIT:   state_nxt_s = ifc.imem_rsp_valid ? IF_SETTLE : IF_WAIT;
            IF_DRAIN:  state_nxt_s = ifc.imem_rsp_valid ? IF_SETTLE : IF_DRAIN;
            default:   state_nxt_s = IF_SETTLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IF_SETTLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Address of the request in flight, paired with its response on push.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_addr_r <= {AW{1'b0}};
      end else if (accept_s) begin
         pend_addr_r <= pc_addr;
      end else begin
         pend_addr_r <= pend_addr_r;
      end
   end

   ifetch_fifo #(
      .W     (AW + DW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .clear (flush),
      .din   ({pend_addr_r, ifc.imem_rsp_data}),
      .head  ({ifc.inst_addr, ifc.inst_data}),
      .count (count_s)
   );

   assign ifc.imem_req_valid = req_valid_s;
   assign ifc.imem_req_addr  = pc_addr;
   assign ifc.inst_valid     = (count_s != {CW{1'b0}});
   assign pc_adv             = !reset && (accept_s || flush);

`ifdef IFETCH_STATS_EN
   logic [31:0] stat_fetch_r;
   logic [31:0] stat_stall_r;
   logic        stall_s;

   assign stall_s = (state_r == IF_REQ) &&
                    ((credits_s == {CW{1'b0}}) || (req_valid_s && !ifc.imem_req_ready));

   // Saturating fetch and stall counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetch_r <= 32'd0;
         stat_stall_r <= 32'd0;
      end else begin
         stat_fetch_r <= accept_s ? sat_inc32(stat_fetch_r) : stat_fetch_r;
         stat_stall_r <= stall_s  ? sat_inc32(stat_stall_r) : stat_stall_r;
      end
   end

   assign stat_fetch = stat_fetch_r;
   assign stat_stall = stat_stall_r;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a PC model, a latency-randomised instruction memory
// and an expected-instruction queue drive directed and random phases.
module tb_ifetch_unit;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_addr;
   logic        pc_adv;
   logic        flush;
`ifdef IFETCH_STATS_EN
   logic [31:0] stat_fetch;
   logic [31:0] stat_stall;
`endif

   ifetch_unit_if #(.AW(32), .DW(32)) bus_if ();

   ifetch_unit #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .pc_addr (pc_addr),
      .pc_adv  (pc_adv),
      .flush   (flush),
      .ifc     (bus_if)
`ifdef IFETCH_STATS_EN
      ,
      .stat_fetch (stat_fetch),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Reference state: expected FIFO contents, the one memory read in flight,
   // the first cycle a request may be issued, and the PC.
   logic [63:0] mq[$];
   bit          m_outst;
   bit          m_live;
   logic [31:0] m_out_addr;
   logic [31:0] m_data;
   int          m_delay;
   int          cyc;
   int          free_at;
   logic [31:0] pc_cnt;
   int          lat_min = 1;
   int          lat_max = 1;
   int          acc_cnt;
   int          adv_obs;
   logic [31:0] acc_q[$];
   int          exp_fetch;
   int          exp_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush = 1'b0;
      pc_addr = 32'd0;
      bus_if.imem_req_ready = 1'b1;
      bus_if.imem_rsp_valid = 1'b1;
      bus_if.imem_rsp_data  = $urandom;
      bus_if.inst_ready     = 1'b1;
      @(posedge clk); #1;
      chk("rst_inst_valid", bus_if.inst_valid, 1'b0);
      chk("rst_inst_data", bus_if.inst_data, 32'd0);
      chk("rst_inst_addr", bus_if.inst_addr, 32'd0);
      chk("rst_req_valid", bus_if.imem_req_valid, 1'b0);
      chk("rst_pc_adv", pc_adv, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus_if.imem_rsp_valid = 1'b0;
      mq.delete();
      m_outst = 1'b0;
      m_live = 1'b0;
      cyc = 0;
      free_at = 1;
      pc_cnt = 32'd0;
      exp_fetch = 0;
      exp_stall = 0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic tick(input bit fl, input logic [31:0] wd, input bit rdy, input bit ird);
      bit          rsp;
      bit          exp_rv;
      bit          exp_acc;
      bit          req_phase;
      bit          pop;
      logic [31:0] pc_old;
      rsp = m_outst && (m_delay == 0);
      flush = fl;
      bus_if.imem_req_ready = rdy;
      bus_if.inst_ready     = ird;
      bus_if.imem_rsp_valid = rsp;
      bus_if.imem_rsp_data  = rsp ? m_data : $urandom;
      #2;
      req_phase = !m_outst && (cyc >= free_at);
      exp_rv = req_phase && (mq.size() < DEPTH);
      exp_acc = exp_rv && rdy;
      chk("req_valid", bus_if.imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", bus_if.imem_req_addr, pc_addr);
      chk("pc_adv", pc_adv, exp_acc || fl);
      chk("inst_valid", bus_if.inst_valid, mq.size() != 0);
      if (mq.size() != 0) chk("inst_head", {bus_if.inst_addr, bus_if.inst_data}, mq[0]);
      if (pc_adv === 1'b1) adv_obs++;
      if (req_phase && exp_acc) exp_fetch++;
      if (req_phase && ((mq.size() == DEPTH) || !rdy)) exp_stall++;
      if (exp_acc) begin
         acc_cnt++;
         acc_q.push_back(pc_addr);
      end
      pop = (mq.size() != 0) && ird;
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (rsp && m_live) mq.push_back({m_out_addr, m_data});
      end
      if (rsp) begin
         m_outst = 1'b0;
         free_at = cyc + 2;
      end else if (m_outst) begin
         m_delay--;
      end
      if (exp_acc) begin
         m_outst = 1'b1;
         m_live = 1'b1;
         m_out_addr = pc_addr;
         m_data = $urandom;
         m_delay = int'($urandom_range(lat_max - 1, lat_min - 1));
      end
      if (fl) begin
         m_live = 1'b0;
         if (!m_outst) free_at = cyc + 2;
      end
      pc_old = pc_cnt;
      if (exp_acc || fl) pc_cnt = fl ? wd : (pc_cnt + 32'd4);
      @(posedge clk); #1;
      pc_addr = pc_old;
      cyc++;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      flush = 1'b0;
      pc_addr = 32'd0;

      // Straight-line fetch from 0 with immediate ready and one-cycle latency.
      lat_min = 1; lat_max = 1;
      do_reset();
      acc_q.delete();
      repeat (14) tick(1'b0, 32'd0, 1'b1, 1'b1);
      chk("t1_naccept", acc_q.size() >= 3, 1'b1);
      if (acc_q.size() >= 3) begin
         chk("t1_addr0", acc_q[0], 32'h0);
         chk("t1_addr1", acc_q[1], 32'h4);
         chk("t1_addr2", acc_q[2], 32'h8);
      end

      // Decode stalled: exactly DEPTH fetches, then one per pop.
      do_reset();
      acc_cnt = 0;
      repeat (25) tick(1'b0, 32'd0, 1'b1, 1'b0);
      chk("t2_fill_accepts", acc_cnt, DEPTH);
      acc_cnt = 0;
      tick(1'b0, 32'd0, 1'b1, 1'b1);
      repeat (10) tick(1'b0, 32'd0, 1'b1, 1'b0);
      chk("t2_pop_accepts", acc_cnt, 1);

      // Memory backpressure for three cycles.
      do_reset();
      adv_obs = 0;
      repeat (4) tick(1'b0, 32'd0, 1'b0, 1'b1);
      chk("t3_no_adv", adv_obs, 0);
      tick(1'b0, 32'd0, 1'b1, 1'b1);
      chk("t3_one_adv", adv_obs, 1);

      // Flush while waiting on a slow response.
      lat_min = 3; lat_max = 3;
      do_reset();
      n = 0;
      while (!(m_outst && m_delay == 2 && mq.size() >= 2) && n < 60) begin
         tick(1'b0, 32'd0, 1'b1, 1'b0);
         n++;
      end
      chk("t4_reach_wait", m_outst && m_delay == 2 && mq.size() >= 2, 1'b1);
      tick(1'b1, 32'h100, 1'b1, 1'b0);
      acc_q.delete();
      n = 0;
      while (acc_q.size() == 0 && n < 20) begin
         tick(1'b0, 32'd0, 1'b1, 1'b1);
         n++;
      end
      chk("t4_target", (acc_q.size() != 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'h100);

      // Flush coinciding with a response.
      lat_min = 2; lat_max = 2;
      n = 0;
      while (!(m_outst && m_delay == 0 && m_live && mq.size() >= 1) && n < 40) begin
         tick(1'b0, 32'd0, 1'b1, 1'b0);
         n++;
      end
      chk("t5_reach_rsp", m_outst && m_delay == 0 && m_live, 1'b1);
      tick(1'b1, 32'h200, 1'b1, 1'b0);
      chk("t5_fifo_empty", bus_if.inst_valid, 1'b0);
      acc_q.delete();
      n = 0;
      while (acc_q.size() == 0 && n < 20) begin
         tick(1'b0, 32'd0, 1'b1, 1'b1);
         n++;
      end
      chk("t5_target", (acc_q.size() != 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'h200);

      // Random traffic with occasional redirects.
      lat_min = 1; lat_max = 4;
      repeat (400) begin
         tick(($urandom % 25) == 0, {$urandom_range(255, 0), 2'b00}, ($urandom % 4) != 0,
              ($urandom % 3) != 0);
      end

      // Reset in the middle of a transaction.
      n = 0;
      while (!m_outst && n < 20) begin
         tick(1'b0, 32'd0, 1'b1, 1'b1);
         n++;
      end
      chk("t7_outst", m_outst, 1'b1);
      lat_min = 1; lat_max = 1;
      do_reset();
      repeat (15) tick(1'b0, 32'd0, 1'b1, 1'b1);

`ifdef IFETCH_STATS_EN
      // Five fetches behind three backpressure cycles.
      do_reset();
      acc_cnt = 0;
      repeat (4) tick(1'b0, 32'd0, 1'b0, 1'b1);
      n = 0;
      while (acc_cnt < 5 && n < 40) begin
         tick(1'b0, 32'd0, 1'b1, 1'b1);
         n++;
      end
      chk("st_fetch", stat_fetch, 32'd5);
      chk("st_stall", stat_stall, 32'd3);
      chk("st_fetch_model", stat_fetch, exp_fetch);
      chk("st_stall_model", stat_stall, exp_stall);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
